// File: rtl/serial_rx_slave.sv
// serial_rx_slave: slave-side receiver for the DRSSTC SFP link.
// Oversamples the NRZ line from the LVDS receiver, decodes 7-bit frames
// (start, pulse, 3 option bits, even parity, stop) and recovers the
// interrupter pulse level and option field. Pulse is forced off on frame
// timeout or SFP loss-of-signal.
// Optional build macro: SERIAL_RX_GLITCH_FILTER_EN adds a 3-tap majority
// filter behind the synchronizer (one extra clock of latency).
`timescale 1ns/1ps

module serial_rx_slave #(
  parameter int BIT_CYC     = 20,
  parameter int TIMEOUT_CYC = 40000
) (
  input  logic       i_clk,
  input  logic       i_res,
  input  logic       i_SerialData,
  input  logic       i_sfp_loss_sig,
  output logic       o_RawPls,
  output logic [2:0] o_Option,
  output logic       o_frame_vld,
  output logic       o_frame_err,
  output logic       o_link_ok,
  output logic       o_rcv_en_n,
  output logic [1:0] o_rx_led
);

  localparam int TMR_W = $clog2(BIT_CYC);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] HALF_LOAD = TMR_W'(BIT_CYC / 2 - 1);
  localparam logic [TMR_W-1:0] FULL_LOAD = TMR_W'(BIT_CYC - 1);
  localparam logic [TO_W-1:0]  TO_MAX    = TO_W'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Synchronizer, edge history and LOS register
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic line_prev_q, line_prev_d;
  logic los_q, los_d;
  logic line;
  logic fall;

  // Frame decoder
  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       data_q, data_d;
  logic             par_q, par_d;
  logic             tmr_exp;
  logic             frame_ok;
  logic             frame_bad;

  // Output side
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            raw_q, raw_d;
  logic [2:0]      opt_q, opt_d;
  logic            fvld_q, fvld_d;
  logic            ferr_q, ferr_d;
  logic            link_q, link_d;
  logic            rcv_en_n_q, rcv_en_n_d;
  logic [1:0]      rx_led_q, rx_led_d;

  // Next values for the front-end flops
  always_comb begin
    sync1_d     = i_SerialData;
    sync2_d     = sync1_q;
    line_prev_d = line;
    los_d       = i_sfp_loss_sig;
  end

  // Front-end registers; line flops idle high so reset never looks like a start edge
  always_ff @(posedge i_clk) begin
    if (i_res) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      line_prev_q <= 1'b1;
      los_q       <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      line_prev_q <= line_prev_d;
      los_q       <= los_d;
    end
  end

`ifdef SERIAL_RX_GLITCH_FILTER_EN
  logic tap1_q, tap1_d;
  logic tap2_q, tap2_d;

  // Delay taps for the majority vote
  always_comb begin
    tap1_d = sync2_q;
    tap2_d = tap1_q;
  end

  // Tap registers, idle high
  always_ff @(posedge i_clk) begin
    if (i_res) begin
      tap1_q <= 1'b1;
      tap2_q <= 1'b1;
    end else begin
      tap1_q <= tap1_d;
      tap2_q <= tap2_d;
    end
  end

  assign line = (sync2_q & tap1_q) | (sync2_q & tap2_q) | (tap1_q & tap2_q);
`else
  assign line = sync2_q;
`endif

  assign fall    = ~line & line_prev_q;
  assign tmr_exp = (tmr_q == '0);

  // Decoder state register
  always_ff @(posedge i_clk) begin
    if (i_res) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
    end
  end

  // Captured bits are qualified by the FSM, so they need no reset
  always_ff @(posedge i_clk) begin
    data_q <= data_d;
    par_q  <= par_d;
  end

  // Next-state logic: mid-bit sampling, timer restarted from each start edge
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_exp ? tmr_q : tmr_q - 1'b1;
    idx_d     = idx_q;
    data_d    = data_q;
    par_d     = par_q;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fall) begin
          tmr_d   = HALF_LOAD;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tmr_exp) begin
          if (!line) begin
            tmr_d   = FULL_LOAD;
            idx_d   = 2'd0;
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (tmr_exp) begin
          data_d[idx_q] = line;
          tmr_d         = FULL_LOAD;
          if (idx_q == 2'd3) begin
            state_d = S_PARITY;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      S_PARITY: begin
        if (tmr_exp) begin
          par_d   = line;
          tmr_d   = FULL_LOAD;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tmr_exp) begin
          if (line && !(^{data_q, par_q})) begin
            frame_ok = 1'b1;
          end else begin
            frame_bad = 1'b1;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (los_q) begin
      state_d   = S_IDLE;
      frame_ok  = 1'b0;
      frame_bad = 1'b0;
    end
  end

  // Output next values: commit beats timeout, LOS forces pulse off
  always_comb begin
    raw_d      = raw_q;
    opt_d      = opt_q;
    link_d     = link_q;
    fvld_d     = frame_ok;
    ferr_d     = frame_bad;
    rcv_en_n_d = 1'b0;
    if (los_q) begin
      to_cnt_d = TO_MAX;
    end else if (frame_ok) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TO_MAX) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end else begin
      to_cnt_d = to_cnt_q;
    end
    if (frame_ok) begin
      raw_d  = data_q[0];
      opt_d  = data_q[3:1];
      link_d = 1'b1;
    end else if (to_cnt_d == TO_MAX) begin
      raw_d  = 1'b0;
      link_d = 1'b0;
    end
    rx_led_d = {raw_d, link_d};
  end

  // Output registers
  always_ff @(posedge i_clk) begin
    if (i_res) begin
      to_cnt_q   <= TO_MAX;
      raw_q      <= 1'b0;
      opt_q      <= 3'b000;
      fvld_q     <= 1'b0;
      ferr_q     <= 1'b0;
      link_q     <= 1'b0;
      rcv_en_n_q <= 1'b1;
      rx_led_q   <= 2'b00;
    end else begin
      to_cnt_q   <= to_cnt_d;
      raw_q      <= raw_d;
      opt_q      <= opt_d;
      fvld_q     <= fvld_d;
      ferr_q     <= ferr_d;
      link_q     <= link_d;
      rcv_en_n_q <= rcv_en_n_d;
      rx_led_q   <= rx_led_d;
    end
  end

  assign o_RawPls    = raw_q;
  assign o_Option    = opt_q;
  assign o_frame_vld = fvld_q;
  assign o_frame_err = ferr_q;
  assign o_link_ok   = link_q;
  assign o_rcv_en_n  = rcv_en_n_q;
  assign o_rx_led    = rx_led_q;

endmodule
